wb_commit_queue: RTL and testbench
==================================

Name: wb_commit_queue

Overview:
Next-generation writeback stage with a commit queue.
- Performs load-data extraction: byte, half, word, plus unaligned LWL/LWR merge with the old rt value.
- Applies the exception write-gate and selects exception overrides.
- Pushes each committed result into a DEPTH-entry FIFO that drains into the register-file/HI-LO write port under a valid/ready handshake.
- Sits between the MEM/WB pipeline register and the register file, decoupling the pipeline from write-port stalls.

Parameters:
DEPTH, 4, commit FIFO entries; power of two, >=2
ADDR_W, 7, register-file write address width
CNT_W, 3, occupancy counter width, = log2(DEPTH)+1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  MEM/WB slot holds an instruction
in_ready  out  1  queue can accept this cycle
flush  in  1  discard all queued and incoming entries
aluout  in  32  ALU result / load byte address
memdata  in  32  raw word read from memory
rt_old  in  32  current rt value, for LWL/LWR merge
mem_to_reg  in  1  1 = write aligned load data, 0 = write aluout
mem_read_type  in  3  [2]=sign-extend; [1:0]: 00 byte, 01 half, 10 word, 11 LWL([2]=0)/LWR([2]=1)
reg_write  in  1  instruction writes the GPR file
wr_addr  in  ADDR_W  GPR destination
exc_addr_sel  in  1  override destination with exc_addr
exc_data_sel  in  1  override data with exc_data
exc_addr  in  ADDR_W  exception destination
exc_data  in  32  exception data
hilo_we_in  in  1  HI/LO write
hilo_in  in  64  HI/LO data
exception_in  in  3  exception code
epc  in  32  EPC of this instruction
pc_in  in  32  instruction PC
out_valid  out  1  queue head is valid
out_ready  in  1  write port consumes the head this cycle
rf_we  out  1  head GPR write enable
rf_addr  out  ADDR_W  head GPR address
rf_data  out  32  head GPR data
hilo_we  out  1  head HI/LO write enable
hilo_data  out  64  head HI/LO data
pc_out  out  32  head PC
exception_out  out  3  head exception code
align_err  out  1  head was a misaligned half load (write suppressed)
count  out  CNT_W  current occupancy

Behaviour:
Reset:
- count=0, out_valid=0, in_ready=1.
- All head outputs read 0: rf_we, rf_addr, rf_data, hilo_we, hilo_data, pc_out, exception_out, align_err. Head fields are masked to 0 whenever the queue is empty.

Load extraction (combinational, offset o=aluout[1:0]):
- Byte: memdata byte o, zero- or sign-extended per [2].
- Half: o=0 selects [15:0], o=2 selects [31:16], extended per [2]. o=1 or o=3 sets align_err.
- Word: memdata unchanged.
- LWL:
  - o=0 {memdata[7:0], rt_old[23:0]}
  - o=1 {memdata[15:0], rt_old[15:0]}
  - o=2 {memdata[23:0], rt_old[7:0]}
  - o=3 memdata
- LWR:
  - o=0 memdata
  - o=1 {rt_old[31:24], memdata[31:8]}
  - o=2 {rt_old[31:16], memdata[31:16]}
  - o=3 {rt_old[31:8], memdata[31:24]}

Entry formation:
- data = exc_data_sel ? exc_data : (mem_to_reg ? load : aluout).
- addr = exc_addr_sel ? exc_addr : wr_addr.
- we = reg_write & ~align_err & (exception_in==0 | (exception_in==6 & epc[1:0]==0)).
- HI/LO, pc and exception fields pass through unchanged.

Handshake:
- in_ready = (count < DEPTH); it does not depend on out_ready, so there is no pass-through when full.
- Push occurs when in_valid & in_ready & ~flush.
- out_valid = (count != 0). Pop occurs when out_valid & out_ready.
- Latency: an entry pushed at edge N is visible at the head in cycle N+1 when the queue was empty.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Entries with we=0 still occupy a slot and are presented for trace/commit.

Pointers:
- Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is updated as +1 on push, -1 on pop, and unchanged on both or neither.

Flush:
- Takes effect at the next edge: count=0 and both pointers=0.
- Any same-cycle push and pop are ignored.
- Flush has priority over everything except rst.

Reset:
- Asserting rst mid-operation clears all state immediately; no pending write reaches the outputs.

Test Plan:
1. Reset, then push LB signed with aluout=0x..01 and memdata=0x0000_80FF -> next cycle rf_data=0xFFFF_FF80, rf_we=1, count=1.
2. LWL o=1 with memdata=0xAABB_CCDD and rt_old=0x1122_3344 -> rf_data=0xCCDD_3344. LWR o=2, same operands -> rf_data=0x1122_AABB.
3. LH with o=1 -> align_err=1, rf_we=0. exception_in=6 with epc=0x..02 -> rf_we=0. exception_in=6 with epc=0x..00 -> rf_we=1.
4. out_ready=0, push 4 entries -> count=4 and in_ready=0. The fifth in_valid is not accepted. Then out_ready=1 -> entries drain in order over 4 cycles, and in_ready returns to 1 after the first pop.
5. Push and pop every cycle for 10 cycles with DEPTH=4 (pointer wrap) -> count stays 1 and PCs emerge in order with 1-cycle latency.
6. Assert flush with count=3 while in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle input is absent. Asserting rst mid-drain -> outputs read 0 immediately.

Source files
------------

// File: rtl/wb_commit_queue.sv
// Writeback stage with load-data extraction, exception gating and a commit FIFO
// that decouples the MEM/WB register from the register-file/HI-LO write port.
module wb_commit_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [31:0]       aluout,
  input  logic [31:0]       memdata,
  input  logic [31:0]       rt_old,
  input  logic              mem_to_reg,
  input  logic [2:0]        mem_read_type,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              exc_addr_sel,
  input  logic              exc_data_sel,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic [31:0]       exc_data,
  input  logic              hilo_we_in,
  input  logic [63:0]       hilo_in,
  input  logic [2:0]        exception_in,
  input  logic [31:0]       epc,
  input  logic [31:0]       pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [31:0]       rf_data,
  output logic              hilo_we,
  output logic [63:0]       hilo_data,
  output logic [31:0]       pc_out,
  output logic [2:0]        exception_out,
  output logic              align_err,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              hilo_we;
    logic [63:0]       hilo;
    logic [31:0]       pc;
    logic [2:0]        exc;
    logic              align_err;
  } entry_t;

  logic [1:0]       off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_data;
  logic             misaligned;
  logic             exc_ok;
  entry_t           in_entry;
  entry_t           head;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  assign off     = aluout[1:0];
  assign ld_byte = memdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? memdata[31:16] : memdata[15:0];

  always_comb begin
    load_data  = memdata;
    misaligned = 1'b0;
    case (mem_read_type[1:0])
      2'b00: load_data = {{24{mem_read_type[2] & ld_byte[7]}}, ld_byte};
      2'b01: begin
        load_data  = {{16{mem_read_type[2] & ld_half[15]}}, ld_half};
        misaligned = mem_to_reg & off[0];
      end
      2'b10: load_data = memdata;
      default: begin
        // [2]=0 selects LWL (high bytes from memory), [2]=1 selects LWR
        if (!mem_read_type[2]) begin
          case (off)
            2'd0:    load_data = {memdata[7:0],  rt_old[23:0]};
            2'd1:    load_data = {memdata[15:0], rt_old[15:0]};
            2'd2:    load_data = {memdata[23:0], rt_old[7:0]};
            default: load_data = memdata;
          endcase
        end else begin
          case (off)
            2'd0:    load_data = memdata;
            2'd1:    load_data = {rt_old[31:24], memdata[31:8]};
            2'd2:    load_data = {rt_old[31:16], memdata[31:16]};
            default: load_data = {rt_old[31:8],  memdata[31:24]};
          endcase
        end
      end
    endcase
  end

  // Code 6 with a word-aligned EPC still commits its register write
  assign exc_ok = (exception_in == 3'd0) | ((exception_in == 3'd6) & (epc[1:0] == 2'b00));

  always_comb begin
    in_entry.we        = reg_write & ~misaligned & exc_ok;
    in_entry.addr      = exc_addr_sel ? exc_addr : wr_addr;
    in_entry.data      = exc_data_sel ? exc_data : (mem_to_reg ? load_data : aluout);
    in_entry.hilo_we   = hilo_we_in;
    in_entry.hilo      = hilo_in;
    in_entry.pc        = pc_in;
    in_entry.exc       = exception_in;
    in_entry.align_err = misaligned;
  end

  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)
        count_reg <= count_reg + CNT_W'(1);
      else if (pop & ~push)
        count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign rf_we         = head.we;
  assign rf_addr       = head.addr;
  assign rf_data       = head.data;
  assign hilo_we       = head.hilo_we;
  assign hilo_data     = head.hilo;
  assign pc_out        = head.pc;
  assign exception_out = head.exc;
  assign align_err     = head.align_err;
  assign count         = count_reg;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed scenarios plus a randomized
// stream checked against a queue-based reference model.
module tb_wb_commit_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, flush;
  logic [31:0] aluout, memdata, rt_old;
  logic mem_to_reg;
  logic [2:0] mem_read_type;
  logic reg_write;
  logic [ADDR_W-1:0] wr_addr, exc_addr;
  logic exc_addr_sel, exc_data_sel;
  logic [31:0] exc_data;
  logic hilo_we_in;
  logic [63:0] hilo_in;
  logic [2:0] exception_in;
  logic [31:0] epc, pc_in;
  logic out_valid, out_ready;
  logic rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [31:0] rf_data;
  logic hilo_we;
  logic [63:0] hilo_data;
  logic [31:0] pc_out;
  logic [2:0] exception_out;
  logic align_err;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  wb_commit_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .aluout(aluout), .memdata(memdata), .rt_old(rt_old), .mem_to_reg(mem_to_reg),
    .mem_read_type(mem_read_type), .reg_write(reg_write), .wr_addr(wr_addr),
    .exc_addr_sel(exc_addr_sel), .exc_data_sel(exc_data_sel), .exc_addr(exc_addr),
    .exc_data(exc_data), .hilo_we_in(hilo_we_in), .hilo_in(hilo_in),
    .exception_in(exception_in), .epc(epc), .pc_in(pc_in), .out_valid(out_valid),
    .out_ready(out_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .hilo_we(hilo_we), .hilo_data(hilo_data), .pc_out(pc_out),
    .exception_out(exception_out), .align_err(align_err), .count(count)
  );

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              hwe;
    logic [63:0]       hilo;
    logic [31:0]       pc;
    logic [2:0]        exc;
    logic              aerr;
  } ent_t;

  int checks = 0;
  int failures = 0;
  ent_t mq[$];

  function automatic ent_t observed();
    ent_t e;
    e.we = rf_we; e.addr = rf_addr; e.data = rf_data; e.hwe = hilo_we;
    e.hilo = hilo_data; e.pc = pc_out; e.exc = exception_out; e.aerr = align_err;
    return e;
  endfunction

  // Reference: computes the committed entry straight from the field rules
  function automatic ent_t model_entry();
    ent_t e;
    int o;
    logic [31:0] ld;
    logic [63:0] m;
    logic aerr;
    o = int'(aluout[1:0]);
    aerr = 1'b0;
    ld = memdata;
    case (mem_read_type[1:0])
      2'b00: begin
        ld = (memdata >> (8 * o)) & 32'hFF;
        if (mem_read_type[2] && ld >= 32'h80) ld = ld | 32'hFFFF_FF00;
      end
      2'b01: begin
        aerr = mem_to_reg && (o % 2 == 1);
        ld = (memdata >> (8 * o)) & 32'hFFFF;
        if (mem_read_type[2] && ld >= 32'h8000) ld = ld | 32'hFFFF_0000;
      end
      2'b10: ld = memdata;
      default: begin
        if (!mem_read_type[2]) begin
          m = (64'd1 << (8 * (3 - o))) - 64'd1;
          ld = 32'(({32'd0, memdata} << (8 * (3 - o))) | ({32'd0, rt_old} & m));
        end else begin
          ld = (memdata >> (8 * o)) | (rt_old & ~(32'hFFFF_FFFF >> (8 * o)));
        end
      end
    endcase
    e.data = exc_data_sel ? exc_data : (mem_to_reg ? ld : aluout);
    e.addr = exc_addr_sel ? exc_addr : wr_addr;
    e.we   = reg_write && !aerr &&
             (exception_in == 3'd0 || (exception_in == 3'd6 && epc % 4 == 0));
    e.hwe  = hilo_we_in;
    e.hilo = hilo_in;
    e.pc   = pc_in;
    e.exc  = exception_in;
    e.aerr = aerr;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0; aluout = 0; memdata = 0; rt_old = 0; mem_to_reg = 0;
    mem_read_type = 3'b010; reg_write = 0; wr_addr = 0; exc_addr_sel = 0;
    exc_data_sel = 0; exc_addr = 0; exc_data = 0; hilo_we_in = 0; hilo_in = 0;
    exception_in = 0; epc = 0; pc_in = 0; out_ready = 0;
  endtask

  task automatic rand_inputs();
    int k;
    aluout = $urandom; memdata = $urandom; rt_old = $urandom;
    mem_to_reg = 1'($urandom_range(0, 1));
    mem_read_type = mem_to_reg ? 3'($urandom_range(0, 7)) : 3'b010;
    reg_write = ($urandom_range(0, 3) != 0);
    wr_addr = ADDR_W'($urandom); exc_addr = ADDR_W'($urandom);
    exc_addr_sel = ($urandom_range(0, 7) == 0);
    exc_data_sel = ($urandom_range(0, 7) == 0);
    exc_data = $urandom;
    hilo_we_in = 1'($urandom_range(0, 1));
    hilo_in = {$urandom, $urandom};
    k = $urandom_range(0, 3);
    exception_in = (k == 0) ? 3'd0 : (k == 1) ? 3'd6 : 3'($urandom);
    epc = $urandom; pc_in = $urandom;
  endtask

  task automatic push_one();
    in_valid = 1;
    $display("push pc=%h addr=%0d type=%b", pc_in, wr_addr, mem_read_type);
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (observed() !== ent_t'(0)) begin failures++; $display("FAIL reset_head got=%h exp=0", observed()); end
    rst = 0;
    tick();
  endtask

  task automatic test_load_extract();
    clear_inputs();
    out_ready = 1;
    mem_to_reg = 1; reg_write = 1; wr_addr = 7'd5; mem_read_type = 3'b100;
    aluout = 32'h0000_1001; memdata = 32'h0000_80FF; pc_in = 32'h10;
    push_one();
    checks++; if (rf_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed_data got=%h exp=ffffff80", rf_data); end
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL lb_we got=%b exp=1", rf_we); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL lb_count got=%0d exp=1", count); end
    checks++; if (rf_addr !== 7'd5) begin failures++; $display("FAIL lb_addr got=%0d exp=5", rf_addr); end
    tick();
    mem_read_type = 3'b011; aluout = 32'h2001; memdata = 32'hAABB_CCDD; rt_old = 32'h1122_3344;
    push_one();
    checks++; if (rf_data !== 32'hCCDD_3344) begin failures++; $display("FAIL lwl_o1 got=%h exp=ccdd3344", rf_data); end
    tick();
    mem_read_type = 3'b111; aluout = 32'h2002;
    push_one();
    checks++; if (rf_data !== 32'h1122_AABB) begin failures++; $display("FAIL lwr_o2 got=%h exp=1122aabb", rf_data); end
    tick();
    mem_read_type = 3'b001; aluout = 32'h1001;
    push_one();
    checks++; if (align_err !== 1'b1) begin failures++; $display("FAIL lh_align_err got=%b exp=1", align_err); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lh_we got=%b exp=0", rf_we); end
    tick();
    mem_to_reg = 0; mem_read_type = 3'b010; exception_in = 3'd6; epc = 32'h0000_0102;
    push_one();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL exc6_misaligned_we got=%b exp=0", rf_we); end
    checks++; if (exception_out !== 3'd6) begin failures++; $display("FAIL exc6_code got=%0d exp=6", exception_out); end
    tick();
    epc = 32'h0000_0100;
    push_one();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL exc6_aligned_we got=%b exp=1", rf_we); end
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL load_drained_count got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    clear_inputs();
    reg_write = 1;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      pc_in = 32'd100 + 32'(i);
      $display("push pc=%h (full test)", pc_in);
      tick();
    end
    in_valid = 0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || pc_out !== 32'd100 + 32'(i)) begin
        failures++; $display("FAIL drain_order got=%0d/%b exp=%0d/1", pc_out, out_valid, 100 + i);
      end
      tick();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_in_ready got=%b exp=1", in_ready); end
      end
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      pc_in = 32'd200 + 32'(i);
      $display("push pc=%h (streaming)", pc_in);
      tick();
      checks++;
      if (count !== 3'd1 || pc_out !== 32'd200 + 32'(i)) begin
        failures++; $display("FAIL stream_wrap got=%0d/cnt%0d exp=%0d/cnt1", pc_out, count, 200 + i);
      end
    end
    in_valid = 0;
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush_and_reset();
    clear_inputs();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'd300 + 32'(i);
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL preflush_count got=%0d exp=3", count); end
    pc_in = 32'd303; flush = 1; out_ready = 1;
    $display("flush with pc=%h incoming", pc_in);
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", count, out_valid); end
    checks++; if (pc_out !== 32'd0) begin failures++; $display("FAIL flush_head got=%h exp=0", pc_out); end
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_input_absent got=%0d exp=0", count); end
    in_valid = 1; reg_write = 1; exc_data_sel = 1; exc_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'd400 + 32'(i);
      tick();
    end
    in_valid = 0; out_ready = 1;
    tick();
    rst = 1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_state got=cnt%0d/%b/%b exp=cnt0/0/1", count, out_valid, in_ready);
    end
    checks++; if (observed() !== ent_t'(0)) begin failures++; $display("FAIL midrst_head got=%h exp=0", observed()); end
    tick();
    rst = 0; out_ready = 0;
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL postrst_count got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    ent_t exp_h, obs_h, ne;
    bit do_push, do_pop;
    clear_inputs();
    mq.delete();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      exp_h = (mq.size() > 0) ? mq[0] : ent_t'(0);
      obs_h = observed();
      if (exp_h.aerr) obs_h.data = exp_h.data;
      checks++; if (obs_h !== exp_h) begin failures++; $display("FAIL rand_head[%0d] got=%h exp=%h", i, obs_h, exp_h); end
      checks++; if (count !== CNT_W'(mq.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count, mq.size()); end
      checks++; if (in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() > 0)) begin
        failures++; $display("FAIL rand_hs[%0d] got=%b/%b size=%0d", i, in_ready, out_valid, mq.size());
      end
      do_push = in_valid && mq.size() < DEPTH && !flush;
      do_pop  = mq.size() > 0 && out_ready && !flush;
      ne = model_entry();
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(ne);
      end
      $display("txn %0d push=%0d pop=%0d flush=%0d pc=%h", i, do_push, do_pop, flush, pc_in);
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_extract();
    test_full();
    test_back_to_back();
    test_flush_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
